mult_div_issue_ctrl: RTL and testbench
======================================

// Module: mult_div_issue_ctrl
// PURPOSE
//   Sequencer for the iterative multiply/divide functional unit in the OoO backend. Accepts one
//   M-extension op at a time from the mult/div reservation station, launches the multi-cycle
//   core, resolves divide special cases itself, and holds the tagged result until the CDB grants it.
//   Sits between the reservation station issue port and the CDB arbiter.
// PARAMETERS
//   PHYS_REG_BITS  6   width of physical destination register tag
//   ROB_IDX_BITS   5   width of ROB index carried with the op
// PORTS
//   clk            in   1    clock; all state updates on posedge
//   rst            in   1    synchronous, active-high reset
//   flush          in   1    pipeline flush (mispredict); kills accepted/in-flight op
//   iss_valid      in   1    reservation station presents an op
//   iss_ready      out  1    controller can accept (state IDLE and !flush)
//   iss_funct3     in   3    mult_div_f3_* encoding (mul..remu)
//   iss_rs1_v      in   32   operand 1
//   iss_rs2_v      in   32   operand 2
//   iss_pd         in   PHYS_REG_BITS  destination physical register
//   iss_rob_idx    in   ROB_IDX_BITS   ROB entry
//   core_start     out  1    one-cycle pulse launching mult_div core
//   core_is_div    out  1    1 = divide/remainder op, 0 = multiply op
//   core_funct3    out  3    latched funct3 to core
//   core_a, core_b out  32   latched operands to core
//   core_abort     out  1    one-cycle pulse cancelling in-flight core op
//   core_done      in   1    core result valid (single-cycle pulse)
//   core_result    in   32   core result (selected half / quotient / remainder)
//   cdb_req        out  1    result buffered, requesting CDB
//   cdb_gnt        in   1    CDB grant; result consumed this cycle
//   cdb_pd         out  PHYS_REG_BITS  tag of buffered result
//   cdb_rob_idx    out  ROB_IDX_BITS   ROB index of buffered result
//   cdb_rd_v       out  32   buffered result value
// BEHAVIOUR
//   Reset: state IDLE; iss_ready=1 (unless flush); core_start, core_abort, cdb_req=0; data regs 0.
//   FSM: IDLE, BUSY, RESP.
//   IDLE: iss_valid&&iss_ready -> latch funct3/operands/pd/rob_idx.
//     Divide special case (funct3[2]=1) resolved here, no core_start, next=RESP:
//       rs2==0: div/divu -> 32'hFFFF_FFFF; rem/remu -> rs1.
//       signed overflow (div/rem, rs1=32'h8000_0000, rs2=32'hFFFF_FFFF): div -> 32'h8000_0000, rem -> 0.
//     Otherwise core_start pulses in the cycle after acceptance, next=BUSY; core_is_div=funct3[2].
//   BUSY: wait for core_done; on core_done latch core_result, next=RESP. core_done in any other
//     state is ignored.
//   RESP: cdb_req=1 with stable cdb_* until cdb_gnt; on grant next=IDLE (no same-cycle re-accept;
//     iss_ready rises the cycle after grant). Min issue-to-cdb_req latency: 1 cycle (special case);
//     core ops: core latency + 1.
//   flush (any state): next=IDLE, cdb_req deasserts next cycle; if BUSY, core_abort pulses
//     for one cycle; an op presented with flush is not accepted. flush beats cdb_gnt in same cycle
//     (result dropped). core_done coincident with flush is discarded.
//   rst mid-operation: same as flush but core_abort not required (core shares rst).
//   Outputs all registered except iss_ready (combinational from state, flush).
// STRUCTURE
//   rv32i_types: mult_div_f3_t enum (mul, mulh, mulhsu, mulhu, div, divu, rem, remu),
//   mdctl_state_t enum, special-case constants (DIV_ZERO_Q, INT_MIN, NEG_ONE).
//   Single flat module; special-case detection is a small function, no sub-module.
//   Pairs with existing fu_mult_div core via core_* ports.
// TESTING
//   mul 3*8, pd=5 rob=2 -> core_start once, after core_done cdb_req, cdb_rd_v=24, pd=5, rob=2.
//   divu 7/0 -> no core_start, cdb_req next cycle, cdb_rd_v=32'hFFFF_FFFF; remu 7/0 -> 7.
//   div 32'h8000_0000/32'hFFFF_FFFF -> cdb_rd_v=32'h8000_0000; rem same operands -> 0.
//   mulh result held with cdb_gnt low 10 cycles -> cdb_* stable, iss_ready=0; gnt -> IDLE next cycle.
//   flush during BUSY -> core_abort one pulse, no cdb_req, later core_done ignored, iss_ready=1.
//   rst asserted in RESP -> cdb_req=0, iss_ready=1 next cycle; back-to-back ops after release pass.

Source files
------------

// File: rtl/mult_div_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_issue_ctrl_pkg
//  Brief    : Shared types and divide special-case helper for the mult/div
//             issue controller.
//  Revision : 1.0 - initial release
// ============================================================================
package mult_div_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } mult_div_f3_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mdctl_state_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE    = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        hit;
        logic [31:0] value;
    } div_special_t;

    // Divide cases whose answer is fixed by the ISA and never reach the core.
    function automatic div_special_t div_special(input logic [2:0]  f3,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        div_special_t r;
        r.hit   = 1'b0;
        r.value = '0;
        if (f3[2]) begin
            if (b == '0) begin
                r.hit   = 1'b1;
                r.value = (f3 == F3_DIV || f3 == F3_DIVU) ? DIV_ZERO_Q : a;
            end else if ((f3 == F3_DIV || f3 == F3_REM) && a == INT_MIN && b == NEG_ONE) begin
                r.hit   = 1'b1;
                r.value = (f3 == F3_DIV) ? INT_MIN : '0;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_issue_ctrl
//  Brief    : Issue sequencer for the iterative mult/div unit; launches the
//             core, resolves divide corner cases and holds the CDB result.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_issue_ctrl
    import mult_div_issue_ctrl_pkg::*;
#(
    parameter int PHYS_REG_BITS = 6,
    parameter int ROB_IDX_BITS  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic [2:0]               iss_funct3,
    input  logic [31:0]              iss_rs1_v,
    input  logic [31:0]              iss_rs2_v,
    input  logic [PHYS_REG_BITS-1:0] iss_pd,
    input  logic [ROB_IDX_BITS-1:0]  iss_rob_idx,
    output logic                     core_start,
    output logic                     core_is_div,
    output logic [2:0]               core_funct3,
    output logic [31:0]              core_a,
    output logic [31:0]              core_b,
    output logic                     core_abort,
    input  logic                     core_done,
    input  logic [31:0]              core_result,
    output logic                     cdb_req,
    input  logic                     cdb_gnt,
    output logic [PHYS_REG_BITS-1:0] cdb_pd,
    output logic [ROB_IDX_BITS-1:0]  cdb_rob_idx,
    output logic [31:0]              cdb_rd_v
);

    mdctl_state_t             state_q, state_d;
    logic                     core_start_q, core_start_d;
    logic                     core_abort_q, core_abort_d;
    logic                     core_is_div_q, core_is_div_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [31:0]              a_q, a_d;
    logic [31:0]              b_q, b_d;
    logic [PHYS_REG_BITS-1:0] pd_q, pd_d;
    logic [ROB_IDX_BITS-1:0]  rob_q, rob_d;
    logic [31:0]              result_q, result_d;
    logic                     cdb_req_q, cdb_req_d;

    logic                     w_accept;
    div_special_t             w_special;

    assign iss_ready = (state_q == ST_IDLE) && !flush;
    assign w_accept  = iss_valid && iss_ready;
    assign w_special = div_special(iss_funct3, iss_rs1_v, iss_rs2_v);

    always_comb begin
        state_d       = state_q;
        core_start_d  = 1'b0;
        core_abort_d  = 1'b0;
        core_is_div_d = core_is_div_q;
        funct3_d      = funct3_q;
        a_d           = a_q;
        b_d           = b_q;
        pd_d          = pd_q;
        rob_d         = rob_q;
        result_d      = result_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    funct3_d      = iss_funct3;
                    a_d           = iss_rs1_v;
                    b_d           = iss_rs2_v;
                    pd_d          = iss_pd;
                    rob_d         = iss_rob_idx;
                    core_is_div_d = iss_funct3[2];
                    if (w_special.hit) begin
                        result_d = w_special.value;
                        state_d  = ST_RESP;
                    end else begin
                        core_start_d = 1'b1;
                        state_d      = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (core_done) begin
                    result_d = core_result;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cdb_gnt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over grant and completion; a pending result is dropped.
        if (flush) begin
            state_d      = ST_IDLE;
            result_d     = result_q;
            core_abort_d = (state_q == ST_BUSY);
        end

        cdb_req_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            core_start_q  <= 1'b0;
            core_abort_q  <= 1'b0;
            core_is_div_q <= 1'b0;
            funct3_q      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            pd_q          <= '0;
            rob_q         <= '0;
            result_q      <= '0;
            cdb_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_start_q  <= core_start_d;
            core_abort_q  <= core_abort_d;
            core_is_div_q <= core_is_div_d;
            funct3_q      <= funct3_d;
            a_q           <= a_d;
            b_q           <= b_d;
            pd_q          <= pd_d;
            rob_q         <= rob_d;
            result_q      <= result_d;
            cdb_req_q     <= cdb_req_d;
        end
    end

    assign core_start  = core_start_q;
    assign core_abort  = core_abort_q;
    assign core_is_div = core_is_div_q;
    assign core_funct3 = funct3_q;
    assign core_a      = a_q;
    assign core_b      = b_q;
    assign cdb_req     = cdb_req_q;
    assign cdb_pd      = pd_q;
    assign cdb_rob_idx = rob_q;
    assign cdb_rd_v    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_issue_ctrl
//  Brief    : Self-checking bench: directed corner cases then random traffic
//             against an ISA-level model of the issue controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [2:0]  iss_funct3 = '0;
    logic [31:0] iss_rs1_v = '0;
    logic [31:0] iss_rs2_v = '0;
    logic [5:0]  iss_pd = '0;
    logic [4:0]  iss_rob_idx = '0;
    logic        core_start, core_is_div, core_abort;
    logic [2:0]  core_funct3;
    logic [31:0] core_a, core_b;
    logic        core_done;
    logic        core_done_c = 1'b0;
    logic        stray_done = 1'b0;
    logic [31:0] core_result = '0;
    logic        cdb_req;
    logic        cdb_gnt = 1'b0;
    logic [5:0]  cdb_pd;
    logic [4:0]  cdb_rob_idx;
    logic [31:0] cdb_rd_v;

    assign core_done = core_done_c | stray_done;

    mult_div_issue_ctrl #(.PHYS_REG_BITS(6), .ROB_IDX_BITS(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_funct3(iss_funct3),
        .iss_rs1_v(iss_rs1_v), .iss_rs2_v(iss_rs2_v), .iss_pd(iss_pd), .iss_rob_idx(iss_rob_idx),
        .core_start(core_start), .core_is_div(core_is_div), .core_funct3(core_funct3),
        .core_a(core_a), .core_b(core_b), .core_abort(core_abort),
        .core_done(core_done), .core_result(core_result),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_pd(cdb_pd),
        .cdb_rob_idx(cdb_rob_idx), .cdb_rd_v(cdb_rd_v)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_start = 0;
    int lat_force = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension result from plain 64-bit arithmetic
    function automatic logic [31:0] isa(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, sa, sb, p;
        int signed   ia, ib;
        logic        ovf;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ia = a;
        ib = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p = '0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // ---------------- reference model (transaction level) ----------------
    logic        m_busy = 0, m_resp = 0, m_start = 0, m_abort = 0;
    logic [2:0]  m_f3 = '0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [5:0]  m_pd = '0;
    logic [4:0]  m_rob = '0;

    always @(posedge clk) begin
        m_start = 0;
        m_abort = 0;
        if (rst) begin
            m_busy = 0;
            m_resp = 0;
        end else if (flush) begin
            m_abort = m_busy;
            m_busy  = 0;
            m_resp  = 0;
        end else if (m_resp) begin
            if (cdb_gnt) m_resp = 0;
        end else if (m_busy) begin
            if (core_done) begin
                m_busy = 0;
                m_resp = 1;
            end
        end else if (iss_valid) begin
            m_f3  = iss_funct3;
            m_a   = iss_rs1_v;
            m_b   = iss_rs2_v;
            m_pd  = iss_pd;
            m_rob = iss_rob_idx;
            m_res = isa(iss_funct3, iss_rs1_v, iss_rs2_v);
            if (is_special(iss_funct3, iss_rs1_v, iss_rs2_v)) m_resp = 1;
            else begin
                m_busy  = 1;
                m_start = 1;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("iss_ready", {31'b0, iss_ready}, {31'b0, !m_busy && !m_resp && !flush});
            chk("cdb_req", {31'b0, cdb_req}, {31'b0, m_resp});
            chk("core_start", {31'b0, core_start}, {31'b0, m_start});
            chk("core_abort", {31'b0, core_abort}, {31'b0, m_abort});
            if (m_resp) begin
                chk("cdb_rd_v", cdb_rd_v, m_res);
                chk("cdb_pd", {26'b0, cdb_pd}, {26'b0, m_pd});
                chk("cdb_rob_idx", {27'b0, cdb_rob_idx}, {27'b0, m_rob});
            end
            if (m_start) begin
                chk("core_a", core_a, m_a);
                chk("core_b", core_b, m_b);
                chk("core_funct3", {29'b0, core_funct3}, {29'b0, m_f3});
                chk("core_is_div", {31'b0, core_is_div}, {31'b0, m_f3[2]});
            end
        end
    end

    // ---------------- behavioural iterative core ----------------
    int          c_cnt = 0;
    logic [31:0] c_res = '0;
    always @(negedge clk) begin
        core_done_c = 0;
        if (rst || core_abort) c_cnt = 0;
        else if (core_start) begin
            n_start++;
            c_cnt = (lat_force != 0) ? lat_force : int'($urandom_range(1, 5));
            c_res = isa(core_funct3, core_a, core_b);
        end else if (c_cnt > 0) begin
            c_cnt--;
            if (c_cnt == 0) core_done_c = 1;
        end
        core_result = core_done_c ? c_res : $urandom();
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] pd, input logic [4:0] rob);
        iss_funct3 = f3; iss_rs1_v = a; iss_rs2_v = b; iss_pd = pd; iss_rob_idx = rob;
        iss_valid = 1;
        for (int i = 0; i < 20 && !iss_ready; i++) cyc();
        if (!iss_ready) chk("issue_timeout", 32'd0, 32'd1);
        cyc();
        iss_valid = 0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 60 && !cdb_req; i++) cyc();
        if (!cdb_req) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic grant();
        cdb_gnt = 1;
        cyc();
        cdb_gnt = 0;
        chk("ready_after_gnt", {31'b0, iss_ready}, 32'd1);
    endtask

    function automatic logic [31:0] pick_a();
        case ($urandom_range(0, 3))
            0: return 32'h8000_0000;
            1: return $urandom_range(0, 20);
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] pick_b();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return $urandom_range(1, 20);
            default: return $urandom();
        endcase
    endfunction

    int s0;

    initial begin
        repeat (3) cyc();
        chk("rst_cdb_rd_v", cdb_rd_v, 32'd0);
        chk("rst_cdb_req", {31'b0, cdb_req}, 32'd0);
        chk("rst_core_a", core_a, 32'd0);
        chk("rst_iss_ready", {31'b0, iss_ready}, 32'd1);
        rst = 0;
        cyc();

        // mul 3*8 through the core
        s0 = n_start;
        issue(3'd0, 32'd3, 32'd8, 6'd5, 5'd2);
        wait_req();
        chk("mul_rd", cdb_rd_v, 32'd24);
        chk("mul_pd", {26'b0, cdb_pd}, 32'd5);
        chk("mul_rob", {27'b0, cdb_rob_idx}, 32'd2);
        chk("mul_starts", n_start - s0, 32'd1);
        grant();

        // divu 7/0 resolved without the core, result on the next cycle
        s0 = n_start;
        issue(3'd5, 32'd7, 32'd0, 6'd9, 5'd3);
        chk("divu0_req", {31'b0, cdb_req}, 32'd1);
        chk("divu0_rd", cdb_rd_v, 32'hFFFF_FFFF);
        grant();
        chk("divu0_starts", n_start - s0, 32'd0);

        issue(3'd7, 32'd7, 32'd0, 6'd10, 5'd4);
        chk("remu0_rd", cdb_rd_v, 32'd7);
        grant();

        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 5'd5);
        chk("div_ovf_rd", cdb_rd_v, 32'h8000_0000);
        grant();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 5'd6);
        chk("rem_ovf_rd", cdb_rd_v, 32'd0);
        grant();

        // mulh held without grant
        issue(3'd1, 32'h4000_0000, 32'd4, 6'd13, 5'd7);
        wait_req();
        for (int i = 0; i < 10; i++) begin
            chk("hold_rd", cdb_rd_v, 32'd1);
            chk("hold_ready", {31'b0, iss_ready}, 32'd0);
            cyc();
        end
        grant();

        // flush while the core is busy, then a stray completion
        lat_force = 8;
        issue(3'd0, 32'd5, 32'd5, 6'd1, 5'd1);
        cyc();
        flush = 1;
        cyc();
        flush = 0;
        chk("flush_abort", {31'b0, core_abort}, 32'd1);
        stray_done = 1;
        cyc();
        stray_done = 0;
        chk("flush_abort_pulse", {31'b0, core_abort}, 32'd0);
        cyc();
        chk("flush_no_req", {31'b0, cdb_req}, 32'd0);
        chk("flush_ready", {31'b0, iss_ready}, 32'd1);
        lat_force = 0;

        // reset in RESP, then back-to-back ops
        issue(3'd7, 32'd9, 32'd0, 6'd2, 5'd2);
        wait_req();
        rst = 1;
        cyc();
        rst = 0;
        chk("rst_resp_req", {31'b0, cdb_req}, 32'd0);
        chk("rst_resp_ready", {31'b0, iss_ready}, 32'd1);
        issue(3'd0, 32'd5, 32'd6, 6'd3, 5'd3);
        wait_req();
        chk("b2b_mul", cdb_rd_v, 32'd30);
        grant();
        issue(3'd4, 32'hFFFF_FFEC, 32'd3, 6'd4, 5'd4);
        wait_req();
        chk("b2b_div", cdb_rd_v, 32'hFFFF_FFFA);
        grant();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            iss_valid  = ($urandom_range(0, 9) < 6);
            iss_funct3 = 3'($urandom_range(0, 7));
            iss_rs1_v  = pick_a();
            iss_rs2_v  = pick_b();
            iss_pd     = 6'($urandom());
            iss_rob_idx = 5'($urandom());
            cdb_gnt    = ($urandom_range(0, 9) < 4);
            stray_done = !m_busy && ($urandom_range(0, 9) == 0);
            cyc();
        end
        rst = 0; flush = 0; iss_valid = 0; stray_done = 0; cdb_gnt = 1;
        repeat (20) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
